// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer that drains the pipeline, strobes the CSR save and redirects fetch on exceptions, interrupts and mret.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_ADDR   = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic        mie_i,
  input  logic [31:0] epc_i,
  output logic        save_epc_o,
  output logic [31:0] epc_pc_o,
  output logic [31:0] mcause_o,
  output logic        mcause_we_o,
  output logic        mret_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DRAIN, SAVE, REDIRECT, MRET} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic take_trap;
  logic [31:0] cause;
  assign take_trap = instr_valid_i & (illegal_i | ecall_i | (irq_i & mie_i));
  assign cause = illegal_i ? 32'h0000_0002 : ecall_i ? 32'h0000_000B : 32'h8000_000B;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = take_trap ? DRAIN : (instr_valid_i & mret_i) ? MRET : IDLE;
      DRAIN:   nxt = (cnt == CNT_LAST) ? SAVE : DRAIN;
      SAVE:    nxt = REDIRECT;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      epc_pc_o    <= '0;
      mcause_o    <= '0;
      stall_o     <= 1'b0;
      flush_o     <= 1'b0;
      save_epc_o  <= 1'b0;
      mcause_we_o <= 1'b0;
      redirect_o  <= 1'b0;
      mret_o      <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= (state == DRAIN) ? cnt + 1'b1 : '0;
      if (state == IDLE && take_trap) begin
        epc_pc_o <= pc_i;
        mcause_o <= cause;
      end
      stall_o     <= nxt inside {DRAIN, SAVE};
      flush_o     <= nxt inside {DRAIN, MRET};
      save_epc_o  <= nxt == SAVE;
      mcause_we_o <= nxt == SAVE;
      redirect_o  <= nxt inside {REDIRECT, MRET};
      mret_o      <= nxt == MRET;
    end
  end
  // mepc is taken live from the CSR during the MRET cycle.
  assign redirect_pc_o = mret_o ? epc_i : redirect_o ? MTVEC_ADDR : '0;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and random stimulus against a timeline model of trap_ctrl.
module tb_trap_ctrl;
  localparam int F = 2;
  localparam logic [31:0] MTVEC = 32'h0000_0100;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid_i = 0, illegal_i = 0, ecall_i = 0, mret_i = 0, irq_i = 0, mie_i = 0;
  logic [31:0] pc_i = 0, epc_i = 0;
  logic save_epc_o, mcause_we_o, mret_o, stall_o, flush_o, redirect_o;
  logic [31:0] epc_pc_o, mcause_o, redirect_pc_o;
  int total = 0, bad = 0, cyc = 0, free_at = 0;
  logic [5:0] e_flags [16];
  logic [1:0] e_sel [16];
  logic [31:0] m_epc = 0, m_cause = 0;

  trap_ctrl #(.MTVEC_ADDR(MTVEC), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid_i), .pc_i(pc_i),
    .illegal_i(illegal_i), .ecall_i(ecall_i), .mret_i(mret_i), .irq_i(irq_i), .mie_i(mie_i),
    .epc_i(epc_i), .save_epc_o(save_epc_o), .epc_pc_o(epc_pc_o), .mcause_o(mcause_o),
    .mcause_we_o(mcause_we_o), .mret_o(mret_o), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      e_flags[i] = '0;
      e_sel[i] = '0;
    end
    m_epc = 0;
    m_cause = 0;
  endtask

  task automatic sched(input int c, input logic [5:0] f, input logic [1:0] s);
    e_flags[c % 16] = f;
    e_sel[c % 16] = s;
  endtask

  // flags: {stall, flush, save_epc, mcause_we, mret, redirect}; sel: 0 zero, 1 mtvec, 2 live mepc
  task automatic cycle(input logic v, il, ec, mr, irq, mie, input logic [31:0] pc, epc);
    logic [31:0] rpc;
    int k;
    instr_valid_i = v; illegal_i = il; ecall_i = ec; mret_i = mr;
    irq_i = irq; mie_i = mie; pc_i = pc; epc_i = epc;
    @(negedge clk);
    k = cyc % 16;
    rpc = (e_sel[k] == 2) ? epc : (e_sel[k] == 1) ? MTVEC : 32'h0;
    chk("flags", {26'h0, stall_o, flush_o, save_epc_o, mcause_we_o, mret_o, redirect_o}, {26'h0, e_flags[k]});
    chk("redirect_pc", redirect_pc_o, rpc);
    chk("epc_pc", epc_pc_o, m_epc);
    chk("mcause", mcause_o, m_cause);
    e_flags[k] = '0;
    e_sel[k] = '0;
    if (cyc >= free_at && v) begin
      if (il || ec || (irq && mie)) begin
        m_epc = pc;
        m_cause = il ? 32'h2 : ec ? 32'hB : 32'h8000_000B;
        for (int i = 1; i <= F; i++) sched(cyc + i, 6'b110000, 2'd0);
        sched(cyc + F + 1, 6'b101100, 2'd0);
        sched(cyc + F + 2, 6'b000001, 2'd1);
        free_at = cyc + F + 3;
      end else if (mr) begin
        sched(cyc + 1, 6'b010011, 2'd2);
        free_at = cyc + 2;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    instr_valid_i = 0; illegal_i = 0; ecall_i = 0; mret_i = 0; irq_i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flags", {26'h0, stall_o, flush_o, save_epc_o, mcause_we_o, mret_o, redirect_o}, 32'h0);
    chk("rst_rpc", redirect_pc_o, 32'h0);
    chk("rst_epc", epc_pc_o, 32'h0);
    chk("rst_cause", mcause_o, 32'h0);
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
    free_at = cyc;
  endtask

  initial begin
    clear_model();
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    // 1: illegal at pc 0x40
    cycle(1, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    idle(6);
    // 2: ecall and irq together
    cycle(1, 0, 1, 0, 1, 1, 32'h80, 32'h0);
    idle(8);
    // 3: masked irq, then enable
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 1, 0, 32'h200 + 32'(i * 4), 32'h0);
    cycle(1, 0, 0, 0, 1, 1, 32'h300, 32'h0);
    idle(6);
    // 4: mret
    cycle(1, 0, 0, 1, 0, 0, 32'h400, 32'h1234);
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h1234);
    idle(3);
    // 5: reset mid-drain
    cycle(1, 0, 1, 0, 0, 0, 32'h500, 32'h0);
    do_reset();
    idle(6);
    // 6: ecall pulsed during save
    cycle(1, 0, 1, 0, 0, 0, 32'h600, 32'h0);
    idle(F);
    cycle(1, 0, 1, 0, 0, 0, 32'h604, 32'h0);
    idle(5);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom, $urandom);
    end
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
